dmem_port: RTL and testbench
============================

DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 Parameter TO_CYC, default 15, is the number of cycles m_req waits for m_ack before timeout (range 1..255).
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port start, input, 1: request one memory transaction; sampled only in IDLE.
REQ-005 Port we, input, 1: 1 = store, 0 = load; sampled with start.
REQ-006 Port addr, input, 16: transaction address; sampled with start.
REQ-007 Port wdata, input, 16: store data (S operand); sampled with start.
REQ-008 Port ds, output, 16: registered load result, fed to the DS leg of the S/DS operand select.
REQ-009 Port busy, output, 1: high while a transaction is in flight.
REQ-010 Port done, output, 1: one-cycle completion pulse.
REQ-011 Port err, output, 1: sticky timeout flag.
REQ-012 Port m_req, output, 1: memory request; held until acknowledged or timed out.
REQ-013 Port m_we, output, 1: memory write enable.
REQ-014 Port m_addr, output, 16: memory address.
REQ-015 Port m_wdata, output, 16: memory write data.
REQ-016 Port m_rdata, input, 16: memory read data; valid when m_ack is high.
REQ-017 Port m_ack, input, 1: memory acknowledge.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ, DONE.
REQ-019 In IDLE with start=1 at edge N, the block SHALL latch we/addr/wdata onto m_we/m_addr/m_wdata, enter REQ, and drive m_req=1 and busy=1 from edge N.
REQ-020 In REQ, m_req, m_we, m_addr and m_wdata SHALL stay stable until exit.
REQ-021 In REQ, m_ack=1 sampled at edge N+k (k>=1) SHALL cause entry to DONE, drop m_req, and, for a load only, load m_rdata into ds at that same edge.
REQ-022 A store SHALL leave ds unchanged.
REQ-023 In DONE, done=1 and busy=1 for exactly one cycle; the next edge SHALL return to IDLE with busy=0.
REQ-024 With zero-wait memory (m_ack=1 on the first REQ cycle), done SHALL be high during the second cycle after start is sampled.
REQ-025 Start asserted in REQ or DONE SHALL be ignored; no queuing.
REQ-026 m_ack in IDLE or DONE SHALL be ignored and SHALL NOT change ds.
REQ-027 A new start SHALL clear err at the edge it is accepted.
REQ-028 ds SHALL hold its value indefinitely between loads.

Reset
REQ-029 On reset assertion, immediately and without a clock: state=IDLE; m_req=0, m_we=0, m_addr=0, m_wdata=0, ds=0, busy=0, done=0, err=0; timeout counter=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it; no done pulse SHALL follow the release of reset.
REQ-031 start sampled at the first edge after reset release SHALL be accepted normally.

Configuration
REQ-032 Macro DMEM_PORT_TIMEOUT_EN compiles in the timeout counter.
REQ-033 With DMEM_PORT_TIMEOUT_EN defined, the counter SHALL clear on REQ entry and increment each REQ cycle without m_ack. When it reaches TO_CYC, the block SHALL drop m_req, set err=1, go to DONE (done pulse) and leave ds unchanged.
REQ-034 If m_ack and the timeout coincide, m_ack SHALL win: normal completion, err unchanged.
REQ-035 Without DMEM_PORT_TIMEOUT_EN, REQ SHALL wait for m_ack indefinitely. err SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-036 Load, addr=0x0040, m_ack one cycle after m_req with m_rdata=0xBEEF -> ds=0xBEEF and done one cycle after the ack edge; busy low the cycle after.
REQ-037 Store, addr=0x0012, wdata=0x1234, m_ack delayed 5 cycles -> m_we=1, m_wdata=0x1234 stable for all 5 cycles; ds keeps its prior value; one done pulse.
REQ-038 start pulsed every cycle during a 3-cycle-wait load -> exactly one transaction and one done pulse.
REQ-039 reset asserted two cycles into REQ -> m_req=0 and ds=0 immediately; no done after release.
REQ-040 With DMEM_PORT_TIMEOUT_EN and TO_CYC=4, m_ack never asserted -> m_req drops after 4 REQ cycles; err=1 and done pulses; next start clears err. Second run with m_ack on the 4th cycle -> normal completion, err=0.

Source files
------------

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - single-transaction data-memory port with req/ack handshake
// Optional timeout counter and sticky err flag: define DMEM_PORT_TIMEOUT_EN.
module dmem_port #(
  parameter int TO_CYC = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] ds,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;

`ifdef DMEM_PORT_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= 16'h0000;
      m_wdata <= 16'h0000;
      ds      <= 16'h0000;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef DMEM_PORT_TIMEOUT_EN
      cnt     <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= REQ;
            m_req   <= 1'b1;
            busy    <= 1'b1;
            m_we    <= we;
            m_addr  <= addr;
            m_wdata <= wdata;
`ifdef DMEM_PORT_TIMEOUT_EN
            cnt     <= 8'd0;
            err_q   <= 1'b0;
`endif
          end
        end
        REQ: begin
          // An ack always beats a coinciding timeout.
          if (m_ack) begin
            state <= DONE;
            m_req <= 1'b0;
            done  <= 1'b1;
            if (!m_we) ds <= m_rdata;
          end
`ifdef DMEM_PORT_TIMEOUT_EN
          else if (cnt == 8'(TO_CYC - 1)) begin
            state <= DONE;
            m_req <= 1'b0;
            done  <= 1'b1;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - directed self-checking bench for dmem_port
module tb_dmem_port;

  logic        clk;
  logic        reset;
  logic        start;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] ds;
  logic        busy;
  logic        done;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ack;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;
  int d0;

  dmem_port #(.TO_CYC(4)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .addr(addr),
    .wdata(wdata), .ds(ds), .busy(busy), .done(done), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0;
    m_rdata = 16'h0; m_ack = 1'b0;
    #23;
    check("rst_ds", 32'(ds), 32'h0);
    check("rst_mreq", 32'(m_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(posedge clk); #1;

    // Load, start present at the first edge after reset release, ack after one cycle.
    reset = 1'b0; start = 1'b1; we = 1'b0; addr = 16'h0040;
    cyc();
    check("ld_mreq", 32'(m_req), 32'h1);
    check("ld_busy", 32'(busy), 32'h1);
    check("ld_maddr", 32'(m_addr), 32'h0040);
    check("ld_mwe", 32'(m_we), 32'h0);
    start = 1'b0; m_ack = 1'b1; m_rdata = 16'hBEEF;
    cyc();
    check("ld_done", 32'(done), 32'h1);
    check("ld_ds", 32'(ds), 32'hBEEF);
    check("ld_mreq_drop", 32'(m_req), 32'h0);
    check("ld_busy_done", 32'(busy), 32'h1);
    m_ack = 1'b0;
    cyc();
    check("ld_busy_end", 32'(busy), 32'h0);
    check("ld_done_end", 32'(done), 32'h0);

    // Store with five-cycle ack delay; ds must keep 0xBEEF.
    d0 = n_done;
    start = 1'b1; we = 1'b1; addr = 16'h0012; wdata = 16'h1234; m_rdata = 16'hDEAD;
    cyc();
    start = 1'b0; wdata = 16'h0000; addr = 16'h0000; we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("st_mreq", 32'(m_req), 32'h1);
      check("st_mwe", 32'(m_we), 32'h1);
      check("st_mwdata", 32'(m_wdata), 32'h1234);
      check("st_maddr", 32'(m_addr), 32'h0012);
      if (i == 4) m_ack = 1'b1;
      cyc();
    end
    check("st_done", 32'(done), 32'h1);
    check("st_ds_keep", 32'(ds), 32'hBEEF);
    m_ack = 1'b0;
    cyc();
    check("st_busy_end", 32'(busy), 32'h0);
    check("st_ndone", 32'(n_done - d0), 32'd1);

    // Start held every cycle during a three-cycle-wait load.
    d0 = n_done;
    start = 1'b1; we = 1'b0; addr = 16'h0080;
    cyc();
    addr = 16'h0099; we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("sp_maddr", 32'(m_addr), 32'h0080);
      check("sp_mwe", 32'(m_we), 32'h0);
      cyc();
    end
    m_ack = 1'b1; m_rdata = 16'h5A5A;
    cyc();
    check("sp_ds", 32'(ds), 32'h5A5A);
    check("sp_done", 32'(done), 32'h1);
    m_ack = 1'b0;
    cyc();
    check("sp_busy_idle", 32'(busy), 32'h0);
    start = 1'b0;
    cyc();
    check("sp_busy_stay", 32'(busy), 32'h0);
    check("sp_ndone", 32'(n_done - d0), 32'd1);

    // Ack while idle must not disturb ds.
    m_ack = 1'b1; m_rdata = 16'hFFFF;
    cyc();
    check("idle_ack_ds", 32'(ds), 32'h5A5A);
    check("idle_ack_done", 32'(done), 32'h0);
    m_ack = 1'b0;

    // Reset two cycles into REQ abandons the transaction.
    start = 1'b1; we = 1'b0; addr = 16'h0010;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    check("rm_mreq_pre", 32'(m_req), 32'h1);
    reset = 1'b1;
    #1;
    check("rm_mreq", 32'(m_req), 32'h0);
    check("rm_ds", 32'(ds), 32'h0);
    check("rm_busy", 32'(busy), 32'h0);
    cyc();
    d0 = n_done;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("rm_ndone", 32'(n_done - d0), 32'd0);
    check("rm_busy_after", 32'(busy), 32'h0);

`ifdef DMEM_PORT_TIMEOUT_EN
    // No ack: timeout after four REQ cycles.
    start = 1'b1; we = 1'b0; addr = 16'h0020; m_rdata = 16'h1111;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_mreq", 32'(m_req), 32'h1);
      cyc();
    end
    check("to_mreq_drop", 32'(m_req), 32'h0);
    check("to_err", 32'(err), 32'h1);
    check("to_done", 32'(done), 32'h1);
    check("to_ds", 32'(ds), 32'h0);
    cyc();
    check("to_err_sticky", 32'(err), 32'h1);
    // Ack on the fourth REQ cycle wins over the timeout.
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("to_err_clr", 32'(err), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("ta_mreq", 32'(m_req), 32'h1);
      if (i == 3) begin
        m_ack = 1'b1; m_rdata = 16'h7777;
      end
      cyc();
    end
    check("ta_done", 32'(done), 32'h1);
    check("ta_err", 32'(err), 32'h0);
    check("ta_ds", 32'(ds), 32'h7777);
    m_ack = 1'b0;
    cyc();
`else
    // No timeout: REQ waits indefinitely, err stays 0.
    start = 1'b1; we = 1'b0; addr = 16'h0020;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    check("nt_mreq", 32'(m_req), 32'h1);
    check("nt_err", 32'(err), 32'h0);
    check("nt_busy", 32'(busy), 32'h1);
    m_ack = 1'b1; m_rdata = 16'h7777;
    cyc();
    m_ack = 1'b0;
    check("nt_ds", 32'(ds), 32'h7777);
    check("nt_done", 32'(done), 32'h1);
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
